acc_predecoder_arbiter: RTL

//  Shares one acc_predecoder among NumReq offloading cores. It arbitrates round-robin over
//  per-core instruction requests and predecodes the granted instruction combinationally.
//  It registers the result and returns it to the granted core over a valid/ready

---
 rtl/acc_pkg.sv | 31 +++
 rtl/acc_predecoder.sv | 30 +++
 rtl/acc_rr_arbiter.sv | 55 +++++
 rtl/acc_predecoder_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types for the accelerator predecoder and its multi-core front-end arbiter.
// Pattern tables, predecoder request/response records and the arbiter FSM state.
package acc_pkg;

    typedef struct packed {
        logic [31:0] instr;
    } acc_prd_req_t;

    typedef struct packed {
        logic       accept;
        logic [1:0] writeback;
        logic [2:0] use_rs;
    } acc_prd_rsp_t;

    // An instruction matches when (instr & instr_mask) == instr_data.
    typedef struct packed {
        logic [31:0]  instr_data;
        logic [31:0]  instr_mask;
        acc_prd_rsp_t prd_rsp;
    } offload_instr_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } prd_arb_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_predecoder.sv
// Combinational predecoder: matches an instruction word against a table of
// offloadable patterns; the lowest-index matching entry supplies the response.
module acc_predecoder
    import acc_pkg::*;
#(
    parameter int unsigned    NumInstr                   = 1,
    parameter offload_instr_t OffloadInstr [NumInstr]    = '{default: '0}
) (
    input  acc_prd_req_t prd_req_i,
    output acc_prd_rsp_t prd_rsp_o
);

    logic [NumInstr-1:0] hit;

    for (genvar gi = 0; gi < NumInstr; gi++) begin : g_match
        assign hit[gi] = ((prd_req_i.instr & OffloadInstr[gi].instr_mask)
                          == OffloadInstr[gi].instr_data);
    end

    // Walk from the top so the lowest matching entry is the one that sticks.
    always_comb begin
        prd_rsp_o = '0;
        for (int i = int'(NumInstr) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                prd_rsp_o = OffloadInstr[i].prd_rsp;
            end
        end
    end

endmodule

// File: rtl/acc_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i,
// wrapping modulo NumReq (works for non-power-of-two NumReq). Pointer is held outside.
module acc_rr_arbiter
    import acc_pkg::*;
#(
    parameter int unsigned NumReq = 2,
    localparam int unsigned IdxW  = idx_width(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_onehot_o,
    output logic [IdxW-1:0]   gnt_idx_o,
    output logic              gnt_any_o
);

    logic [2*NumReq-1:0] req_dbl;
    logic [2*NumReq-1:0] req_shift;
    logic [NumReq-1:0]   req_rot;
    logic [NumReq-1:0]   first_hit;
    logic [IdxW-1:0]     offset;
    logic [IdxW:0]       idx_sum;

    // Rotate so that position 0 of req_rot corresponds to the pointer.
    assign req_dbl   = {req_i, req_i};
    assign req_shift = req_dbl >> ptr_i;
    assign req_rot   = req_shift[NumReq-1:0];

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_first
        if (gi == 0) begin : g_lsb
            assign first_hit[gi] = req_rot[gi];
        end else begin : g_upper
            assign first_hit[gi] = req_rot[gi] & ~(|req_rot[gi-1:0]);
        end
    end

    always_comb begin
        offset = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            if (first_hit[i]) begin
                offset = IdxW'(i);
            end
        end
    end

    assign gnt_any_o = |req_i;
    assign idx_sum   = {1'b0, ptr_i} + {1'b0, offset};
    assign gnt_idx_o = (idx_sum >= (IdxW+1)'(NumReq))
                     ? IdxW'(idx_sum - (IdxW+1)'(NumReq))
                     : IdxW'(idx_sum);

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_onehot
        assign gnt_onehot_o[gi] = gnt_any_o & (gnt_idx_o == IdxW'(gi));
    end

endmodule

// File: rtl/acc_predecoder_arbiter.sv
// Shares one acc_predecoder among NumReq cores: round-robin grant, combinational
// predecode of the granted word, result held in a register until its owner takes it.
module acc_predecoder_arbiter
    import acc_pkg::*;
#(
    parameter int unsigned    NumReq                  = 2,
    parameter int unsigned    NumInstr                = 1,
    parameter offload_instr_t OffloadInstr [NumInstr] = '{default: '0},
    localparam int unsigned   IdxW                    = idx_width(NumReq)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumReq-1:0]   req_valid_i,
    output logic [NumReq-1:0]   req_ready_o,
    input  logic [NumReq*32-1:0] req_instr_i,
    output logic [NumReq-1:0]   rsp_valid_o,
    input  logic [NumReq-1:0]   rsp_ready_i,
    output logic                rsp_accept_o,
    output logic [1:0]          rsp_writeback_o,
    output logic [2:0]          rsp_use_rs_o,
    output logic [IdxW-1:0]     rsp_idx_o
);

    prd_arb_state_e state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] idx_q, idx_d;
    acc_prd_rsp_t    hold_q, hold_d;

    logic [NumReq-1:0] gnt_onehot;
    logic [IdxW-1:0]   gnt_idx;
    logic              gnt_any;
    logic [NumReq-1:0] idx_onehot;
    logic              owner_ready;
    logic              can_grant;
    logic              handshake;
    logic [IdxW-1:0]   next_ptr;
    logic [31:0]       instr_arr [NumReq];
    acc_prd_req_t      prd_req;
    acc_prd_rsp_t      prd_rsp;

    acc_rr_arbiter #(
        .NumReq (NumReq)
    ) u_rr_arbiter (
        .req_i        (req_valid_i),
        .ptr_i        (ptr_q),
        .gnt_onehot_o (gnt_onehot),
        .gnt_idx_o    (gnt_idx),
        .gnt_any_o    (gnt_any)
    );

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_lanes
        assign instr_arr[gi]  = req_instr_i[32*gi +: 32];
        assign idx_onehot[gi] = (idx_q == IdxW'(gi));
    end

    // AND-OR mux on the one-hot grant keeps the instruction path shallow.
    always_comb begin
        prd_req = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            if (gnt_onehot[i]) begin
                prd_req.instr = prd_req.instr | instr_arr[i];
            end
        end
    end

    acc_predecoder #(
        .NumInstr     (NumInstr),
        .OffloadInstr (OffloadInstr)
    ) u_predecoder (
        .prd_req_i (prd_req),
        .prd_rsp_o (prd_rsp)
    );

    // Only the owner's ready can free the holding register; other cores' readies are ignored.
    assign owner_ready = |(rsp_ready_i & idx_onehot);
    assign can_grant   = rst_ni & ((state_q == IDLE) | owner_ready);
    assign handshake   = can_grant & gnt_any;
    assign next_ptr    = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;

    assign req_ready_o     = handshake ? gnt_onehot : '0;
    assign rsp_valid_o     = (state_q == HOLD) ? idx_onehot : '0;
    assign rsp_accept_o    = hold_q.accept;
    assign rsp_writeback_o = hold_q.writeback;
    assign rsp_use_rs_o    = hold_q.use_rs;
    assign rsp_idx_o       = idx_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        if (handshake) begin
            state_d = HOLD;
            ptr_d   = next_ptr;
            idx_d   = gnt_idx;
            hold_d  = prd_rsp;
        end else if ((state_q == HOLD) && owner_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    a_req_ready_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(req_ready_o));

    a_rsp_valid_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(rsp_valid_o));

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_req_stable
        a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (req_valid_i[gi] && !req_ready_o[gi])
            |=> (req_valid_i[gi] && $stable(req_instr_i[32*gi +: 32])));
    end

    a_rsp_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (|(rsp_valid_o & ~rsp_ready_i))
        |=> ($stable(rsp_valid_o) && $stable(hold_q) && $stable(idx_q)));

endmodule
